muldiv_unit: RTL and testbench

- Iterative RV32M/RV64M multiply/divide execution unit, parametrised in XLEN; companion to the main ALU path for the multi-cycle core.
- Decodes funct3 of OP with funct7=0000001, computes one result bit per cycle, and reports completion over a start/done handshake.
- Sits beside the ALU in the execute stage; the controller stalls the pipeline while busy is high.

---
 rtl/muldiv_unit.sv | 150 +++++++++++++++
 tb/tb_muldiv_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one result bit per cycle on operand
// magnitudes, sign fix-up in a final cycle, start/done handshake with flush.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_reg;
    logic [CW-1:0]     count_reg;
    logic [2:0]        op_reg;
    logic [XLEN-1:0]   opnd_reg;
    logic [2*XLEN-1:0] acc_reg;
    logic              neg_main_reg;
    logic              neg_rem_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [XLEN-1:0]   result_reg;

    logic              is_div, a_signed, b_signed, sign_a, sign_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag, min_val;

    assign is_div   = funct3[2];
    assign a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
    assign sign_a   = a_signed & srcA[XLEN-1];
    assign sign_b   = b_signed & srcB[XLEN-1];
    assign a_mag    = sign_a ? -srcA : srcA;
    assign b_mag    = sign_b ? -srcB : srcB;
    assign min_val  = {1'b1, {(XLEN-1){1'b0}}};
    assign div_zero = is_div & (srcB == '0);
    assign div_ovf  = is_div & ~funct3[0] & (srcA == min_val) & (srcB == {XLEN{1'b1}});

    // Multiply keeps the multiplier in the low half and shifts the product in from the top;
    // divide keeps remainder:quotient in the same accumulator and shifts left.
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next;

    assign mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    assign mul_next  = {mul_sum, acc_reg[XLEN-1:1]};
    assign div_shift = acc_reg[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, opnd_reg};
    assign div_next  = div_diff[XLEN] ? {acc_reg[2*XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_value;

    assign prod_fix = neg_main_reg ? -acc_reg : acc_reg;
    assign quo_fix  = neg_main_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
    assign rem_fix  = neg_rem_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];

    always_comb begin
        fix_value = quo_fix;
        case (op_reg)
            3'b000:                fix_value = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_value = prod_fix[2*XLEN-1:XLEN];
            3'b110, 3'b111:        fix_value = rem_fix;
            default:               fix_value = quo_fix;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            op_reg       <= '0;
            opnd_reg     <= '0;
            acc_reg      <= '0;
            neg_main_reg <= 1'b0;
            neg_rem_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            result_reg   <= '0;
        end else if (flush) begin
            state_reg <= IDLE;
            count_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        op_reg   <= funct3;
                        busy_reg <= 1'b1;
                        if (div_zero) begin
                            // Quotient all ones, remainder is the raw dividend.
                            acc_reg      <= {srcA, {XLEN{1'b1}}};
                            neg_main_reg <= 1'b0;
                            neg_rem_reg  <= 1'b0;
                            count_reg    <= '0;
                            state_reg    <= FIX;
                        end else if (div_ovf) begin
                            acc_reg      <= {{XLEN{1'b0}}, srcA};
                            neg_main_reg <= 1'b0;
                            neg_rem_reg  <= 1'b0;
                            count_reg    <= '0;
                            state_reg    <= FIX;
                        end else begin
                            opnd_reg     <= is_div ? b_mag : a_mag;
                            acc_reg      <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
                            neg_main_reg <= sign_a ^ sign_b;
                            neg_rem_reg  <= sign_a;
                            count_reg    <= CW'(XLEN);
                            state_reg    <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_reg   <= op_reg[2] ? div_next : mul_next;
                    count_reg <= count_reg - CW'(1);
                    if (count_reg == CW'(1)) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    result_reg <= fix_value;
                    done_reg   <= 1'b1;
                    state_reg  <= DONE;
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy   = busy_reg;
    assign ready  = ~busy_reg;
    assign done   = done_reg;
    assign result = result_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at XLEN=32 and XLEN=64: stimulus pushes expected
// result and latency from a wide-integer reference model, monitors pop on done.
module tb_muldiv_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, flush, ready, busy, done;
    logic [2:0]  funct3;
    logic [31:0] srcA, srcB, result;

    logic        reset_w, start_w, flush_w, ready_w, busy_w, done_w;
    logic [2:0]  funct3_w;
    logic [63:0] srcA_w, srcB_w, result_w;

    muldiv_unit #(.XLEN(32)) u32 (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .funct3(funct3),
        .srcA(srcA), .srcB(srcB), .ready(ready), .busy(busy), .done(done), .result(result)
    );

    muldiv_unit #(.XLEN(64)) u64 (
        .clk(clk), .reset(reset_w), .start(start_w), .flush(flush_w), .funct3(funct3_w),
        .srcA(srcA_w), .srcB(srcB_w), .ready(ready_w), .busy(busy_w), .done(done_w),
        .result(result_w)
    );

    typedef struct {
        logic [63:0] res;
        int          lat;
        logic [2:0]  f;
    } exp_t;

    exp_t        q32[$];
    exp_t        q64[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [63:0] last32 = '0;
    int          cnt32 = 0;
    int          cnt64 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic on 130-bit signed values, RISC-V corner rules.
    function automatic logic [63:0] ref_res(input int w, input logic [2:0] f,
                                            input logic [63:0] a_in, input logic [63:0] b_in);
        logic signed [129:0] as_v, au_v, bs_v, bu_v, p;
        logic [63:0] mask, amin, a, b;
        mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        amin = (w == 32) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        a = a_in & mask;
        b = b_in & mask;
        au_v = {66'd0, a};
        bu_v = {66'd0, b};
        as_v = ((a & amin) != 0) ? au_v - (130'sd1 <<< w) : au_v;
        bs_v = ((b & amin) != 0) ? bu_v - (130'sd1 <<< w) : bu_v;
        case (f)
            3'd0: begin p = as_v * bs_v; return p[63:0] & mask; end
            3'd1: begin p = (as_v * bs_v) >>> w; return p[63:0] & mask; end
            3'd2: begin p = (as_v * bu_v) >>> w; return p[63:0] & mask; end
            3'd3: begin p = (au_v * bu_v) >>> w; return p[63:0] & mask; end
            3'd4: begin
                if (b == 0) return mask;
                if (a == amin && b == mask) return a;
                p = as_v / bs_v; return p[63:0] & mask;
            end
            3'd5: begin
                if (b == 0) return mask;
                p = au_v / bu_v; return p[63:0] & mask;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == amin && b == mask) return 64'd0;
                p = as_v % bs_v; return p[63:0] & mask;
            end
            default: begin
                if (b == 0) return a;
                p = au_v % bu_v; return p[63:0] & mask;
            end
        endcase
    endfunction

    function automatic int ref_lat(input int w, input logic [2:0] f,
                                   input logic [63:0] a_in, input logic [63:0] b_in);
        logic [63:0] mask, amin;
        mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        amin = (w == 32) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        if (f[2] && (b_in & mask) == 0) return 2;
        if ((f == 3'd4 || f == 3'd6) && (a_in & mask) == amin && (b_in & mask) == mask) return 2;
        return w + 2;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return ($urandom_range(0, 1) == 0) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
            3:       return 64'($urandom_range(0, 9));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic wait_ready32();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout32", 64'(ready), 64'd1);
    endtask

    task automatic issue32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input bit push, input bit use_exp, input logic [31:0] e);
        wait_ready32();
        start = 1'b1; funct3 = f; srcA = a; srcB = b;
        if (push) q32.push_back('{use_exp ? {32'd0, e} : ref_res(32, f, 64'(a), 64'(b)),
                                  ref_lat(32, f, 64'(a), 64'(b)), f});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue64(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                           input bit use_exp, input logic [63:0] e);
        int n = 0;
        @(negedge clk);
        while (!ready_w && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!ready_w) check("ready_timeout64", 64'(ready_w), 64'd1);
        start_w = 1'b1; funct3_w = f; srcA_w = a; srcB_w = b;
        q64.push_back('{use_exp ? e : ref_res(64, f, a, b), ref_lat(64, f, a, b), f});
        @(negedge clk);
        start_w = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            cnt32 = 0;
        end else begin
            cnt32 = busy ? cnt32 + 1 : 0;
            if (done) begin
                if (q32.size() == 0) begin
                    check("unexpected_done32", 64'd1, 64'd0);
                end else begin
                    e = q32.pop_front();
                    check("result32", 64'(result), e.res);
                    check("latency32", 64'(cnt32), 64'(e.lat));
                    last32 = e.res;
                    $display("x32 op=%0d result=0x%08h cycles=%0d", e.f, result, cnt32);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset_w) begin
            cnt64 = 0;
        end else begin
            cnt64 = busy_w ? cnt64 + 1 : 0;
            if (done_w) begin
                if (q64.size() == 0) begin
                    check("unexpected_done64", 64'd1, 64'd0);
                end else begin
                    e = q64.pop_front();
                    check("result64", result_w, e.res);
                    check("latency64", 64'(cnt64), 64'(e.lat));
                    $display("x64 op=%0d result=0x%016h cycles=%0d", e.f, result_w, cnt64);
                end
            end
        end
    end

    initial begin
        int n;
        logic [31:0] a, b;
        reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; srcA = '0; srcB = '0;
        reset_w = 1'b1; start_w = 1'b0; flush_w = 1'b0; funct3_w = '0; srcA_w = '0; srcB_w = '0;
        #2;
        reset = 1'b0; reset_w = 1'b0;
        #1;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_result64", result_w, 64'd0);
        @(negedge clk);
        reset = 1'b1; reset_w = 1'b1;

        // Known answers, including fast paths.
        issue32(3'd0, 32'd7,         32'hFFFF_FFFD, 1, 1, 32'hFFFF_FFEB);
        issue32(3'd1, 32'h8000_0000, 32'h8000_0000, 1, 1, 32'h4000_0000);
        issue32(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 32'hFFFF_FFFE);
        issue32(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 32'hFFFF_FFFF);
        issue32(3'd4, 32'hFFFF_FFF9, 32'd2,         1, 1, 32'hFFFF_FFFD);
        issue32(3'd6, 32'hFFFF_FFF9, 32'd2,         1, 1, 32'hFFFF_FFFF);
        issue32(3'd5, 32'hFFFF_FFF9, 32'd2,         1, 1, 32'h7FFF_FFFC);
        issue32(3'd5, 32'd5,         32'd0,         1, 1, 32'hFFFF_FFFF);
        issue32(3'd7, 32'd5,         32'd0,         1, 1, 32'd5);
        issue32(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 32'h8000_0000);
        issue32(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 32'd0);

        // Flush mid-divide: no done, result keeps the last value.
        issue32(3'd4, 32'h1234_5678, 32'h0000_0123, 0, 0, 32'd0);
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", 64'(ready), 64'd1);
        check("flush_result", 64'(result), last32);
        repeat (40) @(negedge clk);
        check("flush_result_held", 64'(result), last32);

        // Flush wins over start in the same cycle.
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; srcA = 32'd3; srcB = 32'd4;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_over_start", 64'(busy), 64'd0);

        // Asynchronous reset mid-operation.
        issue32(3'd4, 32'h0BAD_F00D, 32'd77, 0, 0, 32'd0);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_ready", 64'(ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        last32 = '0;

        // Start held through busy with changing operands: only the first op runs.
        wait_ready32();
        start = 1'b1; funct3 = 3'd0; srcA = 32'd1234; srcB = 32'd5678;
        q32.push_back('{64'd7006652, 34, 3'd0});
        n = 0;
        do begin
            @(negedge clk);
            srcA = $urandom; srcB = $urandom; funct3 = 3'($urandom_range(0, 7));
            n++;
        end while (!done && n < 200);
        start = 1'b0;
        @(negedge clk);
        check("held_single_op", 64'(busy), 64'd0);

        // Randomised mix; consecutive issues start the cycle after DONE.
        for (int i = 0; i < 40; i++) begin
            a = pick();
            b = pick();
            issue32(3'($urandom_range(0, 7)), a, b, 1, 0, 32'd0);
        end

        // Wide datapath.
        issue64(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1, 64'hFFFF_FFFF_FFFF_FFEB);
        issue64(3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 64'h4000_0000_0000_0000);
        issue64(3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFD);
        issue64(3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        issue64(3'd5, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        issue64(3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h8000_0000_0000_0000);
        for (int i = 0; i < 10; i++) begin
            issue64(3'($urandom_range(0, 7)), pick(), pick(), 0, 64'd0);
        end

        n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain32", 64'(q32.size()), 64'd0);
        check("drain64", 64'(q64.size()), 64'd0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
